// File: rtl/signed_accum.sv
// signed_accum: frame accumulator for the signed product stream.
//   Sums ACC_LEN accepted samples with saturation at ACC_W bits and reports
//   each frame result with a one-cycle valid pulse and a sticky overflow flag.
// Parameters: DIN_W (input width), ACC_W (accumulator/result width, >= DIN_W),
//   ACC_LEN (samples per frame, >= 2).
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   din      - signed input sample
//   din_vld  - din accepted this cycle
//   clr      - synchronous frame abort (priority over din_vld)
//   dout     - signed frame result
//   dout_vld - one-cycle pulse, dout/ovf valid
//   ovf      - saturation occurred in the reported frame
// Optional macro SIGNED_ACCUM_AVG_EN: dout is the frame sum arithmetic-shifted
//   right by log2(ACC_LEN) (floor average); ACC_LEN must be a power of two.
module signed_accum #(
  parameter int DIN_W   = 16,
  parameter int ACC_W   = 24,
  parameter int ACC_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] din,
  input  logic             din_vld,
  input  logic             clr,
  output logic [ACC_W-1:0] dout,
  output logic             dout_vld,
  output logic             ovf
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ACC_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < DIN_W) begin : g_bad_w
    $error("signed_accum: ACC_W must be >= DIN_W");
  end
  if (ACC_LEN < 2) begin : g_bad_len
    $error("signed_accum: ACC_LEN must be >= 2");
  end

`ifdef SIGNED_ACCUM_AVG_EN
  localparam int SHIFT = $clog2(ACC_LEN);
  if (ACC_LEN != (1 << SHIFT)) begin : g_bad_pow2
    $error("signed_accum: ACC_LEN must be a power of two when averaging");
  end
`endif

  logic [ACC_W:0]   din_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] res;
  logic             sat;
  logic             sat_nxt;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    din_ext = {{(ACC_W+1-DIN_W){din[DIN_W-1]}}, din};
    sum     = {acc[ACC_W-1], acc} + din_ext;
    acc_nxt = sum[ACC_W-1:0];
    sat_nxt = sat;
    if (cnt == '0) begin
      // First sample of a frame always fits since ACC_W >= DIN_W.
      acc_nxt = din_ext[ACC_W-1:0];
      sat_nxt = 1'b0;
    end else if (sum[ACC_W] != sum[ACC_W-1]) begin
      // Top two bits disagree: sum left the ACC_W range; sign bit picks the rail.
      acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_nxt = 1'b1;
    end
`ifdef SIGNED_ACCUM_AVG_EN
    res = $signed(acc_nxt) >>> SHIFT;
`else
    res = acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (clr) begin
        cnt <= '0;
        acc <= '0;
        sat <= 1'b0;
      end else if (din_vld) begin
        acc <= acc_nxt;
        sat <= sat_nxt;
        if (cnt == LAST) begin
          cnt      <= '0;
          dout     <= res;
          ovf      <= sat_nxt;
          dout_vld <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_accum.sv
// Bench for signed_accum: two instances (ACC_W=24 default, ACC_W=18) share
// one directed stimulus stream; a frame-level model checks every cycle and
// literal expectations pin the model on the planned scenarios.
module tb_signed_accum;

  localparam int LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        din_vld;
  logic        clr;
  logic [23:0] dout24;
  logic        vld24;
  logic        ovf24;
  logic [17:0] dout18;
  logic        vld18;
  logic        ovf18;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          check_en = 1'b0;

  always #5 clk = ~clk;

  signed_accum #(.DIN_W(16), .ACC_W(24), .ACC_LEN(LEN)) dut24 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .dout(dout24), .dout_vld(vld24), .ovf(ovf24)
  );

  signed_accum #(.DIN_W(16), .ACC_W(18), .ACC_LEN(LEN)) dut18 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .dout(dout18), .dout_vld(vld18), .ovf(ovf18)
  );

  // Frame-level model: collect the accepted samples of a frame, fold them at
  // frame end with clamping at each step.
  longint q[$];
  bit     exp_vld;
  longint exp_d24, exp_d18;
  bit     exp_o24, exp_o18;

  function automatic void fold(input int w, output longint r, output bit s);
    longint mx = (64'sd1 <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    r = q[0];
    s = 1'b0;
    for (int i = 1; i < q.size(); i++) begin
      r = r + q[i];
      if (r > mx) begin r = mx; s = 1'b1; end
      else if (r < mn) begin r = mn; s = 1'b1; end
    end
`ifdef SIGNED_ACCUM_AVG_EN
    r = r >>> $clog2(LEN);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_vld = 1'b0;
      exp_d24 = 0; exp_d18 = 0;
      exp_o24 = 1'b0; exp_o18 = 1'b0;
    end else if (clr) begin
      q.delete();
      exp_vld = 1'b0;
    end else begin
      exp_vld = 1'b0;
      if (din_vld) begin
        q.push_back(longint'($signed(din)));
        if (q.size() == LEN) begin
          fold(24, exp_d24, exp_o24);
          fold(18, exp_d18, exp_o18);
          exp_vld = 1'b1;
          q.delete();
        end
      end
    end
  end

  task automatic cmp(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("vld24", longint'(vld24), longint'(exp_vld));
      cmp("dout24", longint'($signed(dout24)), exp_d24);
      cmp("ovf24", longint'(ovf24), longint'(exp_o24));
      cmp("vld18", longint'(vld18), longint'(exp_vld));
      cmp("dout18", longint'($signed(dout18)), exp_d18);
      cmp("ovf18", longint'(ovf18), longint'(exp_o18));
    end
  end

  task automatic step(input bit v, input int d, input bit c);
    @(negedge clk);
    din_vld = v;
    din     = 16'(d);
    clr     = c;
  endtask

  // Look at the outputs just after the edge that accepted the last sample.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

`ifdef SIGNED_ACCUM_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  initial begin
    rst_n = 1'b0; din_vld = 1'b1; din = 16'd5; clr = 1'b0;
    @(posedge clk);
    check_en = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    cmp("rst_dout", longint'($signed(dout24)), 0);
    cmp("rst_vld", longint'(vld24), 0);
    cmp("rst_ovf", longint'(ovf24), 0);

    // Release reset; 8 contiguous samples of 100.
    @(negedge clk);
    rst_n = 1'b1; din_vld = 1'b1; din = 16'd100;
    for (int i = 1; i < 8; i++) step(1, 100, 0);
    settle();
    cmp("f100_vld", longint'(vld24), 1);
    cmp("f100_dout", longint'($signed(dout24)), AVG ? 100 : 800);
    cmp("f100_ovf", longint'(ovf24), 0);
    step(0, 0, 0);

    // -3 with gaps.
    for (int i = 0; i < 8; i++) begin
      step(1, -3, 0);
      if (i != 7) step(0, 0, 0);
    end
    settle();
    cmp("fneg_dout", longint'($signed(dout24)), AVG ? -3 : -24);
    step(0, 0, 0);

    // Saturation at 18 bits.
    for (int i = 0; i < 8; i++) step(1, 32767, 0);
    settle();
    cmp("satp_dout", longint'($signed(dout18)), AVG ? 16383 : 131071);
    cmp("satp_ovf", longint'(ovf18), 1);
    cmp("satp_ovf24", longint'(ovf24), 0);
    for (int i = 0; i < 8; i++) step(1, -32768, 0);
    settle();
    cmp("satn_dout", longint'($signed(dout18)), AVG ? -16384 : -131072);
    cmp("satn_ovf", longint'(ovf18), 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    settle();
    cmp("sat1_dout", longint'($signed(dout18)), AVG ? 1 : 8);
    cmp("sat1_ovf", longint'(ovf18), 0);

    // Abort mid-frame, then abort on the last sample.
    for (int i = 0; i < 3; i++) step(1, 10, 0);
    step(1, 10, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    settle();
    cmp("clr_dout", longint'($signed(dout24)), AVG ? 1 : 8);
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    step(1, 1, 1);
    settle();
    cmp("clrlast_vld", longint'(vld24), 0);
    cmp("clrlast_dout", longint'($signed(dout24)), AVG ? 1 : 8);

    // Back-to-back frames 1..16.
    for (int i = 1; i <= 16; i++) begin
      step(1, i, 0);
      if (i == 8 || i == 16) begin
        settle();
        cmp("b2b_vld", longint'(vld24), 1);
        cmp("b2b_dout", longint'($signed(dout24)),
            (i == 8) ? (AVG ? 4 : 36) : (AVG ? 12 : 100));
      end
    end

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) step(1, 3, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; din_vld = 1'b1; din = 16'd2;
    for (int i = 1; i < 8; i++) step(1, 2, 0);
    settle();
    cmp("rst2_vld", longint'(vld24), 1);
    cmp("rst2_dout", longint'($signed(dout24)), AVG ? 2 : 16);
    step(0, 0, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
